// File: rtl/avr_lsu_pkg.sv
// Shared definitions for the AVR load/store unit: addressing modes, address map, FSM and region encodings.
package avr_lsu_pkg;

  localparam logic [2:0] LSU_DIRECT  = 3'd0;
  localparam logic [2:0] LSU_IND     = 3'd1;
  localparam logic [2:0] LSU_POSTINC = 3'd2;
  localparam logic [2:0] LSU_PREDEC  = 3'd3;
  localparam logic [2:0] LSU_DISP    = 3'd4;

  localparam logic [15:0] IO_BASE   = 16'h0020;
  localparam logic [15:0] SRAM_BASE = 16'h0060;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IO   = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    RGN_REG  = 2'd0,
    RGN_IO   = 2'd1,
    RGN_SRAM = 2'd2
  } lsu_region_e;

endpackage

// File: rtl/avr_lsu_agen.sv
// Effective-address generator: computes ea, the written-back pointer and the target region.
module avr_lsu_agen
  import avr_lsu_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [15:0] addr,
  input  logic [15:0] ptr,
  input  logic [5:0]  disp,
  output logic [15:0] ea,
  output logic [15:0] ptr_next,
  output lsu_region_e region,
  output logic        illegal
);

  // All arithmetic wraps modulo 2^16, matching the core's 16-bit pointer pairs.
  always_comb begin
    ea       = ptr;
    ptr_next = ptr;
    case (mode)
      LSU_DIRECT:  ea = addr;
      LSU_POSTINC: ptr_next = ptr + 16'd1;
      LSU_PREDEC: begin
        ea       = ptr - 16'd1;
        ptr_next = ptr - 16'd1;
      end
      LSU_DISP:    ea = ptr + {10'd0, disp};
      default: ;
    endcase
  end

  always_comb begin
    region = RGN_SRAM;
    if (ea < IO_BASE)        region = RGN_REG;
    else if (ea < SRAM_BASE) region = RGN_IO;
  end

  assign illegal = (mode > LSU_DISP);

endmodule

// File: rtl/avr_lsu.sv
// AVR load/store unit: latches a core access, drives the I/O strobe or SRAM handshake bus, reports completion.
module avr_lsu
  import avr_lsu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_mode,
  input  logic [15:0]       cmd_addr,
  input  logic [15:0]       cmd_ptr,
  input  logic [5:0]        cmd_disp,
  input  logic [7:0]        cmd_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              ptr_we,
  output logic [15:0]       ptr_out,
  output logic [5:0]        io_addr,
  output logic              io_we,
  output logic              io_re,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e  state, state_nxt;
  lsu_region_e region;
  logic [15:0] ea, ptr_next, ea_q, ptr_q;
  logic        illegal, fault, accept, timeout_hit;
  logic        write_q, ptr_upd_q, err_q;
  logic [7:0]  wdata_q, rdata_q;
  logic [5:0]  io_addr_q;
  logic [CNT_W-1:0] cnt;

  avr_lsu_agen u_agen (
    .mode     (cmd_mode),
    .addr     (cmd_addr),
    .ptr      (cmd_ptr),
    .disp     (cmd_disp),
    .ea       (ea),
    .ptr_next (ptr_next),
    .region   (region),
    .illegal  (illegal)
  );

  assign accept      = (state == ST_IDLE) && cmd_valid;
  assign fault       = illegal || (region == RGN_REG);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        if (fault)                  state_nxt = ST_DONE;
        else if (region == RGN_IO)  state_nxt = ST_IO;
        else                        state_nxt = ST_MEM;
      end
      ST_IO:   state_nxt = ST_DONE;
      ST_MEM:  if (mem_ack || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    err     = done && err_q;
    ptr_we  = done && ptr_upd_q && !err_q;
    io_we   = (state == ST_IO) && write_q;
    io_re   = (state == ST_IO) && !write_q;
    mem_req = (state == ST_MEM);
    mem_we  = mem_req && write_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      write_q   <= 1'b0;
      ptr_upd_q <= 1'b0;
      err_q     <= 1'b0;
      ea_q      <= '0;
      ptr_q     <= '0;
      io_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          write_q   <= cmd_write;
          ptr_upd_q <= (cmd_mode == LSU_POSTINC) || (cmd_mode == LSU_PREDEC);
          err_q     <= fault;
          ea_q      <= ea;
          ptr_q     <= ptr_next;
          io_addr_q <= ea[5:0] - IO_BASE[5:0];
          wdata_q   <= cmd_wdata;
          rdata_q   <= '0;
          cnt       <= '0;
        end
        ST_IO: if (!write_q) rdata_q <= io_rdata;
        ST_MEM: begin
          // Ack wins over timeout when both land in the same cycle.
          if (mem_ack) begin
            if (!write_q) rdata_q <= mem_rdata;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign ptr_out   = ptr_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = wdata_q;
  assign mem_addr  = ea_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_avr_lsu.sv
// Directed self-checking bench for avr_lsu (TIMEOUT_CYC=4 so the abort path is short).
module tb_avr_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_write;
  logic [2:0]  cmd_mode;
  logic [15:0] cmd_addr, cmd_ptr;
  logic [5:0]  cmd_disp;
  logic [7:0]  cmd_wdata;
  logic        busy, done, err, ptr_we, io_we, io_re, mem_req, mem_we, mem_ack;
  logic [7:0]  rdata, io_wdata, io_rdata, mem_wdata, mem_rdata;
  logic [15:0] ptr_out, mem_addr;
  logic [5:0]  io_addr;

  int checks = 0;
  int errors = 0;

  avr_lsu #(.ADDR_W(16), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_ptr(cmd_ptr), .cmd_disp(cmd_disp), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .ptr_we(ptr_we), .ptr_out(ptr_out),
    .io_addr(io_addr), .io_we(io_we), .io_re(io_re), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] md, input logic [15:0] ad,
                       input logic [15:0] pt, input logic [5:0] dq, input logic [7:0] wd);
    cmd_valid = 1'b1; cmd_write = wr; cmd_mode = md;
    cmd_addr = ad; cmd_ptr = pt; cmd_disp = dq; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_mode = 3'd0;
    cmd_addr = '0; cmd_ptr = '0; cmd_disp = '0; cmd_wdata = '0;
    io_rdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0); chk("rst_io_strobes", {io_we, io_re}, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_ptr_out", ptr_out, 0);
    chk("rst_io_addr", io_addr, 0); chk("rst_mem_addr", mem_addr, 0);

    // 1: LD X+ from 0x0100, ack three cycles after req rises
    issue(1'b0, 3'd2, 16'h0, 16'h0100, 6'd0, 8'h00);
    chk("t1_busy", busy, 1);   chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 16'h0100); chk("t1_mem_we", mem_we, 0);
    tick(); tick(); tick();
    chk("t1_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("t1_req_drop", mem_req, 0); chk("t1_done", done, 1); chk("t1_err", err, 0);
    chk("t1_rdata", rdata, 8'hA5);  chk("t1_ptr_we", ptr_we, 1);
    chk("t1_ptr_out", ptr_out, 16'h0101);
    tick();
    chk("t1_idle_busy", busy, 0); chk("t1_idle_done", done, 0);

    // 2: STS 0x003F -> I/O index 0x1F
    issue(1'b1, 3'd0, 16'h003F, 16'h0, 6'd0, 8'h5A);
    chk("t2_io_we", io_we, 1); chk("t2_io_re", io_re, 0);
    chk("t2_io_addr", io_addr, 6'h1F); chk("t2_io_wdata", io_wdata, 8'h5A);
    chk("t2_no_req", mem_req, 0); chk("t2_not_done", done, 0);
    tick();
    chk("t2_done", done, 1); chk("t2_err", err, 0); chk("t2_ptr_we", ptr_we, 0);
    chk("t2_io_we_off", io_we, 0);
    tick();

    // I/O load via Z at 0x0025
    io_rdata = 8'h3C;
    issue(1'b0, 3'd1, 16'h0, 16'h0025, 6'd0, 8'h00);
    chk("io_ld_re", io_re, 1); chk("io_ld_addr", io_addr, 6'h05);
    tick();
    io_rdata = 8'h00;
    chk("io_ld_done", done, 1); chk("io_ld_rdata", rdata, 8'h3C);
    tick();

    // 3: LD -X with X=0, combinational ack
    issue(1'b0, 3'd3, 16'h0, 16'h0000, 6'd0, 8'h00);
    chk("t3_mem_addr", mem_addr, 16'hFFFF); chk("t3_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    chk("t3_done", done, 1); chk("t3_ptr_we", ptr_we, 1);
    chk("t3_ptr_out", ptr_out, 16'hFFFF); chk("t3_rdata", rdata, 8'h77);
    tick();

    // STD Y+63 with Y=0x0FF0
    issue(1'b1, 3'd4, 16'h0, 16'h0FF0, 6'h3F, 8'h99);
    chk("t3_std_addr", mem_addr, 16'h102F); chk("t3_std_we", mem_we, 1);
    chk("t3_std_wdata", mem_wdata, 8'h99);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t3_std_done", done, 1); chk("t3_std_ptr_we", ptr_we, 0);
    tick();

    // Post-inc wraps 0xFFFF -> 0x0000
    issue(1'b0, 3'd2, 16'h0, 16'hFFFF, 6'd0, 8'h00);
    chk("wrap_addr", mem_addr, 16'hFFFF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wrap_ptr_out", ptr_out, 16'h0000); chk("wrap_ptr_we", ptr_we, 1);
    tick();

    // 4: register-space and illegal-mode errors complete at t1
    issue(1'b0, 3'd1, 16'h0, 16'h0010, 6'd0, 8'h00);
    chk("t4_done", done, 1); chk("t4_err", err, 1); chk("t4_rdata", rdata, 8'h00);
    chk("t4_no_bus", {mem_req, io_re, io_we}, 0);
    tick();
    chk("t4_idle", busy, 0);
    issue(1'b0, 3'd6, 16'h0, 16'h0200, 6'd0, 8'h00);
    chk("t4m6_done", done, 1); chk("t4m6_err", err, 1); chk("t4m6_no_req", mem_req, 0);
    tick();
    issue(1'b0, 3'd2, 16'h0, 16'h001F, 6'd0, 8'h00);
    chk("t4pi_err", err, 1); chk("t4pi_ptr_we", ptr_we, 0);
    tick();

    // 5: timeout after exactly 4 request cycles, then a late ack
    issue(1'b0, 3'd1, 16'h0, 16'h0300, 6'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_req_c%0d", i), mem_req, 1);
      chk($sformatf("t5_nodone_c%0d", i), done, 0);
      tick();
    end
    chk("t5_req_off", mem_req, 0); chk("t5_done", done, 1); chk("t5_err", err, 1);
    chk("t5_ptr_we", ptr_we, 0);
    mem_ack = 1'b1;
    tick();
    chk("t5_late_busy", busy, 0); chk("t5_late_done", done, 0);
    tick();
    mem_ack = 1'b0;
    chk("t5_late_req", mem_req, 0);

    // 6: command during busy is dropped; reset aborts without done
    issue(1'b0, 3'd1, 16'h0, 16'h0400, 6'd0, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_mode = 3'd0; cmd_addr = 16'h0030; cmd_wdata = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    chk("t6_still_mem", mem_req, 1); chk("t6_no_io", io_we, 0);
    chk("t6_addr_kept", mem_addr, 16'h0400);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_req", mem_req, 0); chk("t6_busy", busy, 0); chk("t6_done", done, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t6_post_done", done, 0); chk("t6_post_io", io_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
